// File: rtl/t05_data_responder_if.sv
// CPU data request bus between the data request unit (master) and the data responder (slave).
// The T05_DATA_RESP_STATS_EN macro adds the read/write transaction counters.
interface t05_data_responder_if;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 16;

  logic          data_read;
  logic          data_write;
  logic [AW-1:0] data_adr_i;
  logic [DW-1:0] data_bus_i;
  logic [DW-1:0] data_bus_o;
  logic          data_good;
  logic          busy;
  logic          err;
`ifdef T05_DATA_RESP_STATS_EN
  logic [SW-1:0] read_count;
  logic [SW-1:0] write_count;

  modport master (
    output data_read, data_write, data_adr_i, data_bus_i,
    input  data_bus_o, data_good, busy, err, read_count, write_count
  );
  modport slave (
    input  data_read, data_write, data_adr_i, data_bus_i,
    output data_bus_o, data_good, busy, err, read_count, write_count
  );
`else
  modport master (
    output data_read, data_write, data_adr_i, data_bus_i,
    input  data_bus_o, data_good, busy, err
  );
  modport slave (
    input  data_read, data_write, data_adr_i, data_bus_i,
    output data_bus_o, data_good, busy, err
  );
`endif
endinterface

// File: rtl/t05_data_responder.sv
// Memory-side responder for the CPU data request bus: word SRAM, programmable wait states,
// one-cycle data_good completion pulse. Optional counters via T05_DATA_RESP_STATS_EN.
module t05_data_responder #(
  parameter int unsigned ADDR_WORDS  = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  t05_data_responder_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = $clog2(ADDR_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP,
    S_HOLD
  } state_t;

  // Request captured in IDLE; everything after capture works from this copy only.
  typedef struct packed {
    logic          is_read;
    logic          bad;
    logic [IW-1:0] idx;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state;
  req_t          req;
  logic [CW-1:0] wait_cnt;
  logic [DW-1:0] mem [ADDR_WORDS];

  logic          req_c;
  logic          adr_bad_c;

  // Misaligned byte address or any bit above the word index range makes the request bad.
  always_comb begin
    req_c     = bus.data_read | bus.data_write;
    adr_bad_c = (bus.data_adr_i[1:0] != 2'b00) ||
                ((bus.data_adr_i >> (IW + 2)) != AW'(0));
  end

  // Array is never cleared; writes land only in ACCESS for a good write.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_ACCESS) && !req.is_read && !req.bad) begin
      mem[req.idx] <= req.wdata;
    end
  end

  // data_good/err are registered off RESP, so they show in the cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      req            <= '0;
      wait_cnt       <= '0;
      bus.data_bus_o <= '0;
      bus.data_good  <= 1'b0;
      bus.err        <= 1'b0;
      bus.busy       <= 1'b0;
`ifdef T05_DATA_RESP_STATS_EN
      bus.read_count  <= '0;
      bus.write_count <= '0;
`endif
    end else begin
      bus.data_good <= 1'b0;
      bus.err       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_c) begin
            req.is_read <= bus.data_read;
            req.bad     <= adr_bad_c;
            req.idx     <= bus.data_adr_i[IW+1:2];
            req.wdata   <= bus.data_bus_i;
            wait_cnt    <= (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : CW'(0);
            bus.busy    <= 1'b1;
            state       <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          if (wait_cnt == CW'(0)) begin
            state <= S_ACCESS;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        S_ACCESS: begin
          if (req.bad) begin
            bus.data_bus_o <= '0;
          end else if (req.is_read) begin
            bus.data_bus_o <= mem[req.idx];
          end
          state <= S_RESP;
        end
        S_RESP: begin
          bus.data_good <= 1'b1;
          bus.err       <= req.bad;
`ifdef T05_DATA_RESP_STATS_EN
          if (!req.bad && req.is_read) begin
            bus.read_count <= bus.read_count + 16'(1);
          end
          if (!req.bad && !req.is_read) begin
            bus.write_count <= bus.write_count + 16'(1);
          end
`endif
          state <= S_HOLD;
        end
        S_HOLD: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_t05_data_responder.sv
// Directed bench for t05_data_responder: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_t05_data_responder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  t05_data_responder_if bus2 ();
  t05_data_responder_if bus0 ();

  t05_data_responder #(.ADDR_WORDS(256), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );
  t05_data_responder #(.ADDR_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request on the selected instance and observes it until completion.
  task automatic do_req(input bit sel0, input logic rd, input logic wr,
                        input logic [31:0] adr, input logic [31:0] wd,
                        output int lat, output bit one_cycle, output bit busy_all,
                        output bit busy_after, output logic [31:0] rdata, output logic e);
    bit seen;
    @(negedge clk);
    if (sel0) begin
      bus0.data_read = rd; bus0.data_write = wr; bus0.data_adr_i = adr; bus0.data_bus_i = wd;
    end else begin
      bus2.data_read = rd; bus2.data_write = wr; bus2.data_adr_i = adr; bus2.data_bus_i = wd;
    end
    seen = 1'b0; lat = -1; busy_all = 1'b1; rdata = 'x; e = 'x;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (!(sel0 ? bus0.busy : bus2.busy)) busy_all = 1'b0;
      if (sel0 ? bus0.data_good : bus2.data_good) begin
        seen  = 1'b1;
        lat   = k - 1;
        rdata = sel0 ? bus0.data_bus_o : bus2.data_bus_o;
        e     = sel0 ? bus0.err : bus2.err;
        break;
      end
    end
    bus0.data_read = 1'b0; bus0.data_write = 1'b0;
    bus2.data_read = 1'b0; bus2.data_write = 1'b0;
    @(negedge clk);
    one_cycle  = seen && !(sel0 ? bus0.data_good : bus2.data_good);
    busy_after = sel0 ? bus0.busy : bus2.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus2.data_good !== 1'b0) begin errors++; $display("FAIL reset_good: got %b expected 0", bus2.data_good); end
    checks++; if (bus2.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus2.err); end
    checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus2.busy); end
    checks++; if (bus2.data_bus_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", bus2.data_bus_o); end
  endtask

  task automatic test_write_read();
    int lat; bit one, ball, bafter; logic [31:0] rd; logic e;
    do_req(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, one, ball, bafter, rd, e);
    checks++; if (lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d expected 4", lat); end
    checks++; if (one !== 1'b1) begin errors++; $display("FAIL wr_good_width: got %b expected 1", one); end
    checks++; if (ball !== 1'b1) begin errors++; $display("FAIL wr_busy_during: got %b expected 1", ball); end
    checks++; if (bafter !== 1'b0) begin errors++; $display("FAIL wr_busy_after: got %b expected 0", bafter); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", e); end
    do_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, one, ball, bafter, rd, e);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d expected 4", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", e); end
    repeat (3) @(negedge clk);
    checks++; if (bus2.data_bus_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_hold: got %h expected deadbeef", bus2.data_bus_o); end
  endtask

  task automatic test_read_priority();
    int lat; bit one, ball, bafter; logic [31:0] rd; logic e;
    do_req(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, lat, one, ball, bafter, rd, e);
    do_req(1'b0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, lat, one, ball, bafter, rd, e);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL both_read_data: got %h expected 12345678", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL both_err: got %b expected 0", e); end
    do_req(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, lat, one, ball, bafter, rd, e);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL both_mem_kept: got %h expected 12345678", rd); end
  endtask

  task automatic test_bad_address();
    int lat; bit one, ball, bafter; logic [31:0] rd; logic e;
    do_req(1'b0, 1'b0, 1'b1, 32'h13, 32'hAAAA5555, lat, one, ball, bafter, rd, e);
    checks++; if (lat !== 4) begin errors++; $display("FAIL mis_good: got latency %0d expected 4", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", e); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_data: got %h expected 00000000", rd); end
    do_req(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, lat, one, ball, bafter, rd, e);
    checks++; if (lat !== 4) begin errors++; $display("FAIL range_good: got latency %0d expected 4", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_err: got %b expected 1", e); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL range_data: got %h expected 00000000", rd); end
    checks++; if (one !== 1'b1) begin errors++; $display("FAIL range_err_width: got %b expected 1", one); end
    // 0x13 aliases word 4 (0x10) if the misalignment were ignored.
    do_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, lat, one, ball, bafter, rd, e);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL bad_mem_kept: got %h expected deadbeef", rd); end
  endtask

  task automatic test_reset_mid();
    int lat; bit one, ball, bafter; logic [31:0] rd; logic e;
    do_req(1'b0, 1'b0, 1'b1, 32'h30, 32'h11111111, lat, one, ball, bafter, rd, e);
    @(negedge clk);
    bus2.data_write = 1'b1; bus2.data_adr_i = 32'h30; bus2.data_bus_i = 32'h22222222;
    @(negedge clk);
    checks++; if (bus2.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_wait: got %b expected 1", bus2.busy); end
    bus2.data_write = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus2.busy); end
    checks++; if (bus2.data_good !== 1'b0) begin errors++; $display("FAIL mid_good: got %b expected 0", bus2.data_good); end
    do_req(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, lat, one, ball, bafter, rd, e);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL mid_old_value: got %h expected 11111111", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; bit one, ball, bafter; logic [31:0] rd; logic e;
    int pulses;
    int pos [3];
    logic [31:0] pdata [3];
    do_req(1'b1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, lat, one, ball, bafter, rd, e);
    checks++; if (lat !== 2) begin errors++; $display("FAIL w0_latency: got %0d expected 2", lat); end
    @(negedge clk);
    bus0.data_read = 1'b1; bus0.data_adr_i = 32'h8;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus0.data_good) begin
        if (pulses < 3) begin pos[pulses] = k; pdata[pulses] = bus0.data_bus_o; end
        pulses++;
        if (pulses == 3) bus0.data_read = 1'b0;
      end
    end
    bus0.data_read = 1'b0;
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
    if (pulses >= 3) begin
      checks++; if (pos[0] !== 3) begin errors++; $display("FAIL b2b_first: got %0d expected 3", pos[0]); end
      checks++; if (pos[1] - pos[0] !== 4) begin errors++; $display("FAIL b2b_gap1: got %0d expected 4", pos[1] - pos[0]); end
      checks++; if (pos[2] - pos[1] !== 4) begin errors++; $display("FAIL b2b_gap2: got %0d expected 4", pos[2] - pos[1]); end
      checks++; if (pdata[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_data0: got %h expected cafef00d", pdata[0]); end
      checks++; if (pdata[2] !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_data2: got %h expected cafef00d", pdata[2]); end
    end
`ifdef T05_DATA_RESP_STATS_EN
    checks++; if (bus0.read_count !== 16'd3) begin errors++; $display("FAIL stats_reads: got %0d expected 3", bus0.read_count); end
    checks++; if (bus0.write_count !== 16'd1) begin errors++; $display("FAIL stats_writes: got %0d expected 1", bus0.write_count); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus2.data_read = 1'b0; bus2.data_write = 1'b0; bus2.data_adr_i = '0; bus2.data_bus_i = '0;
    bus0.data_read = 1'b0; bus0.data_write = 1'b0; bus0.data_adr_i = '0; bus0.data_bus_i = '0;
    test_reset();
    test_write_read();
    test_read_priority();
    test_bad_address();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
